// File: rtl/wbs_colorbar_pkg.sv
// rtl/wbs_colorbar_pkg.sv - shared types and constants for the colorbar slave arbiter
//
// Purpose: FSM state encoding and Wishbone cycle-type constants used by the
// arbiter top and its testbench.
// Ports: none (package).

package wbs_colorbar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_EOB  = 3'b111;
  localparam logic [2:0] CTI_INCR = 3'b010;

endpackage

// File: rtl/wbs_arb_rr2.sv
// rtl/wbs_arb_rr2.sv - two-way round-robin pick, purely combinational
//
// Purpose: choose one of two requesters; on a tie the one not granted last wins.
// Ports:
//   req  in  2  request vector {m1, m0}
//   last in  1  index of the master granted last (0 = m0, 1 = m1)
//   gnt  out 2  one-hot pick, 2'b00 when nobody requests

module wbs_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wbs_colorbar_arb.sv
// rtl/wbs_colorbar_arb.sv - two-master Wishbone arbiter for the colorbar pattern slave
//
// Purpose: share the read-only 64-bit colorbar slave between two SGDMA read
// channels with round-robin grant, burst hold, fairness pre-emption and a
// stall watchdog.
// Ports:
//   wb_clk_i, wb_rst_i                 clock, async active-high reset
//   mN_cyc_i/stb_i/we_i/sel_i/cti_i    master N request (N = 0, 1)
//   mN_dat_o/ack_o/err_o/rty_o         master N response
//   s_cyc_o/stb_o/we_o/sel_o/cti_o     to slave
//   s_dat_i/ack_i/err_i/rty_i          from slave
//   gnt_o                              one-hot current owner

module wbs_colorbar_arb
  import wbs_colorbar_pkg::*;
#(
  parameter int MAX_BEATS = 256,
  parameter int TIMEOUT   = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [7:0]  m0_sel_i,
  input  logic [2:0]  m0_cti_i,
  output logic [63:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [7:0]  m1_sel_i,
  input  logic [2:0]  m1_cti_i,
  output logic [63:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [7:0]  s_sel_o,
  output logic [2:0]  s_cti_o,
  input  logic [63:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  gnt_o
);

  localparam logic [9:0] BEAT_LAST = 10'(MAX_BEATS - 1);
  localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [9:0] beat_q, beat_d;
  logic [9:0] wdog_q, wdog_d;
  logic       rty_q, rty_d;
  logic       err_q, err_d;

  logic [1:0] req, pick;
  logic       in_grant, in_drain;
  logic       own1, own_cyc, own_stb, own_we, oth_cyc;
  logic [7:0] own_sel;
  logic [2:0] own_cti;
  logic       end_c, preempt, timeout;

  assign req = {m1_cyc_i, m0_cyc_i};

  wbs_arb_rr2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  assign in_grant = (state_q == GRANT);
  assign in_drain = (state_q == DRAIN);

  assign own1    = gnt_q[1];
  assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own1 ? m1_stb_i : m0_stb_i;
  assign own_we  = own1 ? m1_we_i  : m0_we_i;
  assign own_sel = own1 ? m1_sel_i : m0_sel_i;
  assign own_cti = own1 ? m1_cti_i : m0_cti_i;
  assign oth_cyc = own1 ? m0_cyc_i : m1_cyc_i;

  // Slave side only sees the owner while in GRANT; IDLE and DRAIN are quiet.
  assign s_cyc_o = in_grant & own_cyc;
  assign s_stb_o = in_grant & own_cyc & own_stb;
  assign s_we_o  = in_grant & own_we;
  assign s_sel_o = in_grant ? own_sel : 8'h00;
  assign s_cti_o = in_grant ? own_cti : 3'b000;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Acks only pass in GRANT, so the trailing registered ack in DRAIN is dropped.
  // The pre-emption rty and watchdog err are replayed from flags in DRAIN.
  assign m0_ack_o = in_grant & gnt_q[0] & s_ack_i;
  assign m1_ack_o = in_grant & gnt_q[1] & s_ack_i;
  assign m0_err_o = gnt_q[0] & ((in_grant & s_err_i) | (in_drain & err_q));
  assign m1_err_o = gnt_q[1] & ((in_grant & s_err_i) | (in_drain & err_q));
  assign m0_rty_o = gnt_q[0] & ((in_grant & s_rty_i) | (in_drain & rty_q));
  assign m1_rty_o = gnt_q[1] & ((in_grant & s_rty_i) | (in_drain & rty_q));

  assign gnt_o = gnt_q;

  // A normal end (cyc drop, end of burst, slave err/rty) takes precedence, so
  // pre-emption and watchdog never add an rty/err on top of a clean release.
  assign end_c   = ~own_cyc | (s_ack_i & (own_cti == CTI_EOB)) | s_err_i | s_rty_i;
  assign preempt = ~end_c & s_ack_i & (beat_q == BEAT_LAST) & oth_cyc;
  assign timeout = ~end_c & s_stb_o & ~s_ack_i & (wdog_q == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    rty_d   = 1'b0;
    err_d   = 1'b0;
    wdog_d  = (in_grant & s_stb_o & ~s_ack_i) ? wdog_q + 10'd1 : 10'd0;
    case (state_q)
      IDLE: begin
        if (|pick) begin
          state_d = GRANT;
          gnt_d   = pick;
          beat_d  = 10'd0;
        end
      end
      GRANT: begin
        if (s_ack_i) beat_d = beat_q + 10'd1;
        if (end_c | preempt | timeout) begin
          state_d = DRAIN;
          rty_d   = preempt;
          err_d   = timeout;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      beat_q  <= 10'd0;
      wdog_q  <= 10'd0;
      rty_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      wdog_q  <= wdog_d;
      rty_q   <= rty_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/wbs_colorbar_arb.md
Name: wbs_colorbar_arb

Overview:
- Two-requester Wishbone arbiter in front of the single 64-bit read-only colorbar pattern slave.
- Lets two SGDMA read channels share one pattern source: round-robin grant, burst hold, fairness pre-emption, stall watchdog.
- Sits between the DMA masters and the pattern slave. Slave acks one cycle after stb (registered) and ignores cyc on ack.

Parameters:
- MAX_BEATS, 256, acked beats allowed per grant before pre-emption when the other master is waiting. Range 1..1023.
- TIMEOUT, 64, cycles of stb without ack before the watchdog terminates the cycle. Range 2..1023.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 bus cycle, strobe, write enable
- m0_sel_i  in  8  master 0 byte enables
- m0_cti_i  in  3  master 0 cycle type
- m0_dat_o  out  64  read data to master 0
- m0_ack_o, m0_err_o, m0_rty_o  out  1 each  master 0 termination
- m1_*  same set and widths as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_sel_o  out  8  to slave
- s_cti_o  out  3  to slave
- s_dat_i  in  64  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination
- gnt_o  out  2  one-hot current grant (debug/status)

Behaviour:
- Reset: state IDLE; gnt_o=2'b00; last-granted pointer=1, so m0 wins the first tie; beat and watchdog counters 0.
- Reset outputs: all s_* outputs 0; all m*_ack/err/rty 0.
- States: IDLE, GRANT (owner recorded in gnt), DRAIN.
- IDLE: requests are m0_cyc_i and m1_cyc_i.
  - Exactly one requesting: that master is granted.
  - Both requesting: the master not granted last is granted.
  - Grant registers on the next clock. s_stb_o stays 0 while in IDLE. Grant latency is 1 cycle.
- GRANT: owner's cyc, stb, we, sel and cti pass combinationally to s_*. s_stb_o = owner stb AND owner cyc.
  - s_dat_i goes to both m*_dat_o unconditionally.
  - s_ack_i, s_err_i and s_rty_i go only to the owner. The non-owner always sees ack/err/rty = 0.
- Leaving GRANT for DRAIN. Any of the following moves the block to DRAIN on the next clock:
  - Owner drops cyc.
  - Acked beat with owner cti==3'b111 (end of burst).
  - s_err_i or s_rty_i asserted.
  - Pre-emption: beat counter reaches MAX_BEATS with an ack while the other master's cyc=1. The owner gets m_rty_o=1 for 1 cycle in the cycle after that ack (the DRAIN entry cycle). The owner must re-request later.
  - Watchdog reaches TIMEOUT. The owner gets m_err_o=1 for 1 cycle (DRAIN entry cycle), and s_cyc_o is forced low that cycle.
- Beat counter: 10 bits. Increments on each forwarded ack. Clears on every entry to GRANT.
- Watchdog: increments each GRANT cycle with s_stb_o=1 and s_ack_i=0. Clears on ack or when s_stb_o=0.
- DRAIN: exactly 1 cycle. s_cyc_o=s_stb_o=0. Any s_ack_i this cycle (the trailing registered ack) is absorbed and never forwarded. Then IDLE; the last-granted pointer is updated to the outgoing owner.
- Back-to-back: the minimum gap between grants is 2 cycles (DRAIN + IDLE). This guarantees no stale ack is delivered to the new owner.
- Write attempts (we=1) are forwarded unmodified; the slave ignores them.
- Reset mid-burst: all outputs go to reset values immediately (async). Pending acks are lost.
- Simultaneous owner cyc drop and pre-emption condition: treated as a normal release. No rty is asserted.

Decomposition:
- Shared package wbs_colorbar_pkg holds:
  - state encoding constants (IDLE=2'd0, GRANT=2'd1, DRAIN=2'd2);
  - CTI_EOB=3'b111 and CTI_INCR=3'b010.
- One sub-module, wbs_arb_rr2: 2-way round-robin pick from request vector and last pointer; combinational.
- Counters and the FSM stay in the top module.

Test Plan:
- Single master: m0 incrementing burst of 8 beats (cti 010, last 111) -> gnt_o=01 one cycle after cyc; 8 m0_ack_o; data matches slave; DRAIN then IDLE; m1 sees no ack.
- Tie: m0 and m1 raise cyc in the same cycle, twice in succession -> first grant m0, second grant m1. Grants are ≥2 cycles apart; no ack leaks across the switch.
- Pre-emption, MAX_BEATS=4: m0 runs an open-ended burst while m1 requests -> m0 gets 4 acks then m0_rty_o for 1 cycle; m1 is granted 2 cycles later.
- Trailing ack: m0 drops cyc in the cycle stb is issued -> the slave's next-cycle ack is absorbed in DRAIN; neither master sees it.
- Watchdog, TIMEOUT=4: slave model withholds ack -> m0_err_o=1 exactly 1 cycle after 4 unacked stb cycles; s_cyc_o low next cycle; IDLE after DRAIN.
- Async reset asserted mid-burst (beat 3) -> all outputs 0 within the same cycle; after release, first tie goes to m0.
